multi_channel_ingress: RTL and testbench

MULTI_CHANNEL_INGRESS -- requirements
Module: multi_channel_ingress

---
 rtl/ingress_pkg.sv | 28 ++
 rtl/axi_if.sv | 15 +
 rtl/ingress_rate_div.sv | 21 ++
 rtl/multi_channel_ingress.sv | 139 +++++++++++++
 tb/tb_multi_channel_ingress.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ingress_pkg.sv
// Shared types for the multi-channel ingress generator: the pattern modes,
// the FSM states and the sideband width.
package ingress_pkg;

    localparam int USER_W = 4;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_STRIDE = 2'd1,
        MODE_CONST  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // The reserved encoding 3 behaves as the count pattern.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_STRIDE;
            2'd2:    return MODE_CONST;
            default: return MODE_COUNT;
        endcase
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI-Stream link. A beat transfers on a rising edge where tvalid and tready
// are both high; once raised, tvalid and the payload hold until that transfer.
interface axi_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = ingress_pkg::USER_W
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/ingress_rate_div.sv
// Sample-tick divider: while run is high, pulses tick once every div+1 cycles;
// the count is held at zero while run is low.
module ingress_rate_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] div,
    output logic        tick
);
    logic [15:0] r_cnt;

    assign tick = run && (r_cnt == div);

    always_ff @(posedge clk) begin
        if (rst || !run || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/multi_channel_ingress.sv
// Multi-channel test-pattern source: packs NUM_CH generated samples per beat and
// streams fixed-length packets on an AXI-Stream master, counting drops.
module multi_channel_ingress
    import ingress_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int DATA_W   = 32,
    parameter int PKT_LEN  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] rate_div,
    axi_if.master       m_axi,
    output logic [31:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        busy,
    output state_t      o_dbg_state
);
    if (NUM_CH * SAMPLE_W != DATA_W) begin : g_bad_width
        $error("multi_channel_ingress: NUM_CH*SAMPLE_W must equal DATA_W");
    end
    if (PKT_LEN < 2) begin : g_bad_len
        $error("multi_channel_ingress: PKT_LEN must be at least 2");
    end

    localparam int IDX_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    state_t             r_state, w_next_state;
    mode_t              r_mode;
    logic [15:0]        r_rate_div;
    logic               r_tvalid, r_tlast, r_sop;
    logic [DATA_W-1:0]  r_tdata;
    logic [IDX_W-1:0]   r_beat_idx;
    logic [31:0]        r_pkt_count;
    logic [15:0]        r_drop_count;
    logic               w_tick, w_hs, w_can_load, w_load, w_drop, w_partial;
    logic [DATA_W-1:0]  w_beat;

    assign w_hs    = r_tvalid && m_axi.tready;
    assign w_drop  = w_tick && r_tvalid && !m_axi.tready;
    // A packet is open if beats remain or a beat is still waiting, unless that
    // waiting beat is the tlast leaving in this very cycle.
    assign w_partial = (r_beat_idx != '0) || (r_tvalid && !w_hs);
    // Once en is low only the remainder of the open packet may be loaded.
    assign w_can_load = ((r_state == RUN) && en) || ((r_state != IDLE) && (r_beat_idx != '0));
    assign w_load     = w_tick && w_can_load && (!r_tvalid || m_axi.tready);

    ingress_rate_div u_div (
        .clk  (clk),
        .rst  (rst),
        .run  (r_state != IDLE),
        .div  (r_rate_div),
        .tick (w_tick)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [SAMPLE_W-1:0] C_INIT  = SAMPLE_W'(k);
        localparam logic [SAMPLE_W-1:0] C_CONST = {SAMPLE_W{C_INIT[0]}} ^ C_INIT;
        logic [SAMPLE_W-1:0] r_ch;
        logic [SAMPLE_W-1:0] w_step;

        assign w_step = (r_mode == MODE_STRIDE) ? SAMPLE_W'(k + 1) :
                        (r_mode == MODE_CONST)  ? '0 : SAMPLE_W'(1);
        assign w_beat[k*SAMPLE_W +: SAMPLE_W] = (r_mode == MODE_CONST) ? C_CONST : r_ch;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ch <= C_INIT;
            end else if (w_load) begin
                r_ch <= r_ch + w_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (en) w_next_state = RUN;
            RUN:     if (!en) w_next_state = w_partial ? DRAIN : IDLE;
            DRAIN:   if (w_hs && r_tlast) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= MODE_COUNT;
            r_rate_div   <= '0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tlast      <= 1'b0;
            r_sop        <= 1'b0;
            r_beat_idx   <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if ((r_state == IDLE) && en) begin
                r_mode     <= decode_mode(mode);
                r_rate_div <= rate_div;
            end
            if (w_load) begin
                r_tvalid   <= 1'b1;
                r_tdata    <= w_beat;
                r_tlast    <= (r_beat_idx == LAST_IDX);
                r_sop      <= (r_beat_idx == '0);
                r_beat_idx <= (r_beat_idx == LAST_IDX) ? '0 : r_beat_idx + IDX_W'(1);
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end
            if (w_hs && r_tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign m_axi.tvalid = r_tvalid;
    assign m_axi.tdata  = r_tdata;
    assign m_axi.tlast  = r_tlast;
    assign m_axi.tuser  = {{(USER_W-1){1'b0}}, r_sop};
    assign pkt_count    = r_pkt_count;
    assign drop_count   = r_drop_count;
    assign busy         = (r_state != IDLE) || r_tvalid;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_multi_channel_ingress.sv
// Bench for multi_channel_ingress: a 2x16 instance and a 4x8 instance, each
// with a scoreboard queue of expected {tuser, tlast, tdata} beats.
module tb_multi_channel_ingress;
    import ingress_pkg::*;

    localparam int EW = 32 + 1 + USER_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, en_a, tready_a, busy_a;
    logic [1:0]  mode_a;
    logic [15:0] rate_a, drop_a;
    logic [31:0] pkt_a;
    state_t      st_a;
    logic        rst_b, en_b, tready_b, busy_b;
    logic [1:0]  mode_b;
    logic [15:0] rate_b, drop_b;
    logic [31:0] pkt_b;
    state_t      st_b;

    axi_if #(.DATA_W(32)) axi_a ();
    axi_if #(.DATA_W(32)) axi_b ();
    assign axi_a.tready = tready_a;
    assign axi_b.tready = tready_b;

    multi_channel_ingress #(.NUM_CH(2), .SAMPLE_W(16), .DATA_W(32), .PKT_LEN(64)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .rate_div(rate_a), .m_axi(axi_a),
        .pkt_count(pkt_a), .drop_count(drop_a), .busy(busy_a), .o_dbg_state(st_a)
    );
    multi_channel_ingress #(.NUM_CH(4), .SAMPLE_W(8), .DATA_W(32), .PKT_LEN(64)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .rate_div(rate_b), .m_axi(axi_b),
        .pkt_count(pkt_b), .drop_count(drop_b), .busy(busy_b), .o_dbg_state(st_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] exp_q_a[$];
    logic [EW-1:0] exp_q_b[$];
    logic [15:0]   m_a[2];
    logic [7:0]    m_b[4];
    int            m_idx_a, m_idx_b;
    int            hs_a, hs_b, tlast_cyc_a;
    logic [31:0]   first_a, second_b;
    logic [USER_W-1:0] first_u_a;
    logic [7:0]    ch0_255_b, ch0_256_b;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) m_a[k] = 16'(k);
        for (int k = 0; k < 4; k++) m_b[k] = 8'(k);
        m_idx_a = 0;
        m_idx_b = 0;
        exp_q_a.delete();
        exp_q_b.delete();
        hs_a = 0;
        hs_b = 0;
    endtask

    // Expected beat sequence: independent of timing, since drops never advance.
    task automatic push_a(input int n, input int md);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = (md == 2) ? 32'hFFFE_0000 : {m_a[1], m_a[0]};
            exp_q_a.push_back({USER_W'(m_idx_a == 0), (m_idx_a == 63), d});
            if (md != 2)
                for (int k = 0; k < 2; k++) m_a[k] = m_a[k] + ((md == 1) ? 16'(k + 1) : 16'd1);
            m_idx_a = (m_idx_a + 1) % 64;
        end
    endtask

    task automatic push_b(input int n, input int md);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = (md == 2) ? 32'hFC02_FE00 : {m_b[3], m_b[2], m_b[1], m_b[0]};
            exp_q_b.push_back({USER_W'(m_idx_b == 0), (m_idx_b == 63), d});
            if (md != 2)
                for (int k = 0; k < 4; k++) m_b[k] = m_b[k] + ((md == 1) ? 8'(k + 1) : 8'd1);
            m_idx_b = (m_idx_b + 1) % 64;
        end
    endtask

    task automatic monitor_a();
        logic [EW-1:0] got, exp;
        forever begin
            @(negedge clk);
            if (!rst_a && axi_a.tvalid && axi_a.tready) begin
                got = {axi_a.tuser, axi_a.tlast, axi_a.tdata};
                n_checks++;
                if (exp_q_a.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_a_extra beat=%0d got=%h expected no beat", hs_a, got);
                end else begin
                    exp = exp_q_a.pop_front();
                    if (got !== exp) begin
                        n_errors++;
                        $display("FAIL sb_a beat=%0d got=%h expected=%h", hs_a, got, exp);
                    end
                end
                if (axi_a.tlast) tlast_cyc_a = cyc;
                if (hs_a == 0) begin
                    first_a   = axi_a.tdata;
                    first_u_a = axi_a.tuser;
                end
                hs_a++;
            end
        end
    endtask

    task automatic monitor_b();
        logic [EW-1:0] got, exp;
        forever begin
            @(negedge clk);
            if (!rst_b && axi_b.tvalid && axi_b.tready) begin
                got = {axi_b.tuser, axi_b.tlast, axi_b.tdata};
                n_checks++;
                if (exp_q_b.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_b_extra beat=%0d got=%h expected no beat", hs_b, got);
                end else begin
                    exp = exp_q_b.pop_front();
                    if (got !== exp) begin
                        n_errors++;
                        $display("FAIL sb_b beat=%0d got=%h expected=%h", hs_b, got, exp);
                    end
                end
                if (hs_b == 1)   second_b  = axi_b.tdata;
                if (hs_b == 255) ch0_255_b = axi_b.tdata[7:0];
                if (hs_b == 256) ch0_256_b = axi_b.tdata[7:0];
                hs_b++;
            end
        end
    endtask

    task automatic wait_hs_a(input int n, input int budget, output bit ok);
        int b;
        b = budget;
        while (hs_a < n && b > 0) begin step(); b--; end
        ok = (hs_a >= n);
    endtask

    task automatic wait_hs_b(input int n, input int budget, output bit ok);
        int b;
        b = budget;
        while (hs_b < n && b > 0) begin step(); b--; end
        ok = (hs_b >= n);
    endtask

    task automatic wait_idle_a(input int budget, output bit ok);
        int b;
        b = budget;
        while (busy_a && b > 0) begin step(); b--; end
        ok = !busy_a;
    endtask

    task automatic wait_idle_b(input int budget, output bit ok);
        int b;
        b = budget;
        while (busy_b && b > 0) begin step(); b--; end
        ok = !busy_b;
    endtask

    task automatic do_reset();
        rst_a = 1'b1; en_a = 1'b0; mode_a = 2'd0; rate_a = 16'd0; tready_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 2'd0; rate_b = 16'd0; tready_b = 1'b1;
        step();
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 8;
        if (axi_a.tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid got=%b exp=0", axi_a.tvalid); end
        if (axi_a.tdata !== 32'h0) begin n_errors++; $display("FAIL reset_tdata got=%h exp=0", axi_a.tdata); end
        if (axi_a.tlast !== 1'b0) begin n_errors++; $display("FAIL reset_tlast got=%b exp=0", axi_a.tlast); end
        if (axi_a.tuser !== '0) begin n_errors++; $display("FAIL reset_tuser got=%h exp=0", axi_a.tuser); end
        if (pkt_a !== 32'd0) begin n_errors++; $display("FAIL reset_pkt got=%0d exp=0", pkt_a); end
        if (drop_a !== 16'd0) begin n_errors++; $display("FAIL reset_drop got=%0d exp=0", drop_a); end
        if (busy_a !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        if (st_b !== IDLE || axi_b.tvalid !== 1'b0) begin
            n_errors++; $display("FAIL reset_b state=%0d tvalid=%b exp IDLE/0", st_b, axi_b.tvalid);
        end
    endtask

    task automatic test_count_packet();
        bit ok;
        do_reset();
        push_a(128, 0);
        en_a = 1'b1;
        wait_hs_a(64, 200, ok);
        n_checks += 2;
        if (!ok) begin n_errors++; $display("FAIL count_timeout got=%0d beats exp=64", hs_a); end
        if (pkt_a !== 32'd1) begin n_errors++; $display("FAIL count_pkt1 got=%0d exp=1", pkt_a); end
        wait_hs_a(66, 50, ok);
        en_a = 1'b0;
        wait_idle_a(300, ok);
        n_checks += 3;
        if (!ok) begin n_errors++; $display("FAIL count_idle_timeout busy=%b exp=0", busy_a); end
        if (exp_q_a.size() != 0) begin n_errors++; $display("FAIL count_left got=%0d exp=0", exp_q_a.size()); end
        if (pkt_a !== 32'd2) begin n_errors++; $display("FAIL count_pkt2 got=%0d exp=2", pkt_a); end
    endtask

    task automatic test_const();
        bit ok;
        do_reset();
        mode_a = 2'd2;
        push_a(64, 2);
        en_a = 1'b1;
        step();
        mode_a = 2'd0;
        wait_hs_a(5, 50, ok);
        en_a = 1'b0;
        wait_idle_a(200, ok);
        n_checks += 2;
        if (!ok || exp_q_a.size() != 0) begin
            n_errors++; $display("FAIL const_done busy=%b left=%0d exp 0/0", busy_a, exp_q_a.size());
        end
        if (pkt_a !== 32'd1) begin n_errors++; $display("FAIL const_pkt got=%0d exp=1", pkt_a); end
    endtask

    task automatic test_drain();
        bit ok;
        bit seen;
        do_reset();
        push_a(64, 0);
        en_a = 1'b1;
        wait_hs_a(10, 50, ok);
        en_a = 1'b0;
        step();
        n_checks++;
        if (st_a !== DRAIN) begin n_errors++; $display("FAIL drain_enter got=%0d exp=%0d", st_a, DRAIN); end
        en_a = 1'b1;
        repeat (3) step();
        n_checks++;
        if (st_a !== DRAIN) begin n_errors++; $display("FAIL drain_no_abort got=%0d exp=%0d", st_a, DRAIN); end
        en_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (st_a == IDLE) seen = 1'b1;
        end
        n_checks += 4;
        if (!seen) begin n_errors++; $display("FAIL drain_timeout state=%0d exp=IDLE", st_a); end
        if (cyc != tlast_cyc_a + 1) begin
            n_errors++; $display("FAIL drain_idle_cycle got=%0d exp=%0d", cyc, tlast_cyc_a + 1);
        end
        if (busy_a !== 1'b0) begin n_errors++; $display("FAIL drain_busy got=%b exp=0", busy_a); end
        if (hs_a != 64 || exp_q_a.size() != 0) begin
            n_errors++; $display("FAIL drain_beats got=%0d left=%0d exp 64/0", hs_a, exp_q_a.size());
        end
    endtask

    task automatic test_stride();
        bit ok;
        do_reset();
        mode_b = 2'd1;
        push_b(64, 1);
        en_b = 1'b1;
        wait_hs_b(3, 50, ok);
        en_b = 1'b0;
        wait_idle_b(200, ok);
        n_checks += 3;
        if (!ok || exp_q_b.size() != 0) begin
            n_errors++; $display("FAIL stride_done busy=%b left=%0d exp 0/0", busy_b, exp_q_b.size());
        end
        if (second_b !== 32'h0705_0301) begin
            n_errors++; $display("FAIL stride_second got=%h exp=07050301", second_b);
        end
        if (pkt_b !== 32'd1) begin n_errors++; $display("FAIL stride_pkt got=%0d exp=1", pkt_b); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int unstable;
        logic [31:0] held;
        do_reset();
        rate_a = 16'd3;
        tready_a = 1'b0;
        push_a(64, 0);
        en_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (axi_a.tvalid) ok = 1'b1;
        end
        held = axi_a.tdata;
        unstable = 0;
        repeat (16) begin
            step();
            if (axi_a.tvalid !== 1'b1 || axi_a.tdata !== held) unstable++;
        end
        n_checks += 4;
        if (!ok) begin n_errors++; $display("FAIL bp_first_timeout tvalid=%b exp=1", axi_a.tvalid); end
        if (held !== 32'h0001_0000) begin n_errors++; $display("FAIL bp_held got=%h exp=00010000", held); end
        if (unstable != 0) begin n_errors++; $display("FAIL bp_stable got=%0d changes exp=0", unstable); end
        if (drop_a !== 16'd4) begin n_errors++; $display("FAIL bp_drops got=%0d exp=4", drop_a); end
        tready_a = 1'b1;
        wait_hs_a(3, 50, ok);
        en_a = 1'b0;
        wait_idle_a(400, ok);
        n_checks += 2;
        if (!ok || exp_q_a.size() != 0) begin
            n_errors++; $display("FAIL bp_done busy=%b left=%0d exp 0/0", busy_a, exp_q_a.size());
        end
        if (drop_a !== 16'd4) begin n_errors++; $display("FAIL bp_drops_final got=%0d exp=4", drop_a); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        push_b(320, 0);
        en_b = 1'b1;
        wait_hs_b(300, 400, ok);
        en_b = 1'b0;
        wait_idle_b(200, ok);
        n_checks += 4;
        if (!ok || exp_q_b.size() != 0) begin
            n_errors++; $display("FAIL wrap_done busy=%b left=%0d exp 0/0", busy_b, exp_q_b.size());
        end
        if (ch0_255_b !== 8'hFF) begin n_errors++; $display("FAIL wrap_ch0_255 got=%h exp=ff", ch0_255_b); end
        if (ch0_256_b !== 8'h00) begin n_errors++; $display("FAIL wrap_ch0_256 got=%h exp=00", ch0_256_b); end
        if (pkt_b !== 32'd5) begin n_errors++; $display("FAIL wrap_pkt got=%0d exp=5", pkt_b); end
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_reset();
        tready_a = 1'b0;
        en_a = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (axi_a.tvalid) ok = 1'b1;
        end
        repeat (3) step();
        rst_a = 1'b1;
        en_a = 1'b0;
        step();
        n_checks += 5;
        if (!ok) begin n_errors++; $display("FAIL mrst_pending_timeout tvalid=%b exp=1", axi_a.tvalid); end
        if (axi_a.tvalid !== 1'b0) begin n_errors++; $display("FAIL mrst_tvalid got=%b exp=0", axi_a.tvalid); end
        if (pkt_a !== 32'd0) begin n_errors++; $display("FAIL mrst_pkt got=%0d exp=0", pkt_a); end
        if (drop_a !== 16'd0) begin n_errors++; $display("FAIL mrst_drop got=%0d exp=0", drop_a); end
        if (busy_a !== 1'b0) begin n_errors++; $display("FAIL mrst_busy got=%b exp=0", busy_a); end
        rst_a = 1'b0;
        model_reset();
        tready_a = 1'b1;
        push_a(64, 0);
        en_a = 1'b1;
        wait_hs_a(2, 50, ok);
        en_a = 1'b0;
        wait_idle_a(200, ok);
        n_checks += 3;
        if (!ok || exp_q_a.size() != 0) begin
            n_errors++; $display("FAIL mrst_done busy=%b left=%0d exp 0/0", busy_a, exp_q_a.size());
        end
        if (first_a !== 32'h0001_0000) begin n_errors++; $display("FAIL mrst_first got=%h exp=00010000", first_a); end
        if (first_u_a !== USER_W'(1)) begin n_errors++; $display("FAIL mrst_sop got=%h exp=1", first_u_a); end
    endtask

    initial begin
        model_reset();
        fork
            monitor_a();
            monitor_b();
        join_none
        test_reset();
        test_count_packet();
        test_const();
        test_drain();
        test_stride();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
